// File: rtl/div_scheduler_if.sv
// Port bundle between the job scheduler and the single shared unsigned divider.
// The scheduler side is master; the divider side is slave.
interface div_scheduler_if #(
   parameter int WIDTH = 61
);
   logic [WIDTH-1:0] div_dividend_out;
   logic [WIDTH-1:0] div_divisor_out;
   logic             div_start_out;
   logic [WIDTH-1:0] div_quotient_in;
   logic             div_valid_in;
   logic             div_error_in;
   logic             div_busy_in;

   modport master (
      output div_dividend_out, div_divisor_out, div_start_out,
      input  div_quotient_in, div_valid_in, div_error_in, div_busy_in
   );

   modport slave (
      input  div_dividend_out, div_divisor_out, div_start_out,
      output div_quotient_in, div_valid_in, div_error_in, div_busy_in
   );
endinterface

// File: rtl/div_scheduler.sv
// Time-shares one unsigned divider between NJOBS signed division jobs and
// presents all signed, saturated quotients together with one valid pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start_in; results held
//   S_SCAN  | find next enabled job; zero divisors resolved here as errors
//   S_ISSUE | operands registered; strobe divider once it is not busy
//   S_WAIT  | waiting for divider result or timeout
//   S_DONE  | pulse valid_out, drop busy_out
module div_scheduler #(
   parameter int WIDTH   = 61,
   parameter int QWIDTH  = 32,
   parameter int NJOBS   = 4,
   parameter int SHW     = 6,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    start_in,
   input  logic [NJOBS-1:0]        en_in,
   input  logic [NJOBS*WIDTH-1:0]  num_in,
   input  logic [NJOBS*WIDTH-1:0]  den_in,
   input  logic [NJOBS*SHW-1:0]    shift_in,
   output logic                    busy_out,
   output logic [NJOBS*QWIDTH-1:0] quot_out,
   output logic [NJOBS-1:0]        err_out,
   output logic                    valid_out,
   div_scheduler_if.master         div
);

   localparam int JW = (NJOBS > 1) ? $clog2(NJOBS) : 1;
   localparam int IW = JW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [WIDTH-1:0] MAXQ = WIDTH'((64'd1 << (QWIDTH - 1)) - 64'd1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                    state_q;
   logic [WIDTH-1:0]          num_q [NJOBS];
   logic [WIDTH-1:0]          den_q [NJOBS];
   logic [SHW-1:0]            sh_q  [NJOBS];
   logic [NJOBS-1:0]          en_q;
   logic [IW-1:0]             idx_q;
   logic [JW-1:0]             cur_q;
   logic [TW-1:0]             tmo_q;
   logic                      neg_q;
   logic [WIDTH-1:0]          dvd_q;
   logic [WIDTH-1:0]          dvs_q;
   logic                      start_q;
   logic                      busy_q;
   logic                      valid_q;
   logic [NJOBS*QWIDTH-1:0]   quot_q;
   logic [NJOBS-1:0]          err_q;

   logic                      found;
   logic [JW-1:0]             fidx;
   logic [WIDTH-1:0]          num_sel;
   logic [WIDTH-1:0]          den_sel;
   logic [WIDTH-1:0]          abs_num;
   logic [WIDTH-1:0]          abs_den;
   logic [WIDTH-1:0]          dvd_sel;
   logic                      sat;
   logic [QWIDTH-1:0]         mag;
   logic [QWIDTH-1:0]         res;

   // Downward sweep so the lowest enabled index at or above idx_q wins.
   always_comb begin
      found = 1'b0;
      fidx  = '0;
      for (int j = NJOBS - 1; j >= 0; j--) begin
         if (en_q[j] && (IW'(j) >= idx_q)) begin
            found = 1'b1;
            fidx  = JW'(j);
         end
      end
   end

   // abs() of the most negative value wraps to 2^(WIDTH-1), which is the
   // correct unsigned magnitude.
   always_comb begin
      num_sel = num_q[fidx];
      den_sel = den_q[fidx];
      abs_num = num_sel[WIDTH-1] ? (~num_sel + 1'b1) : num_sel;
      abs_den = den_sel[WIDTH-1] ? (~den_sel + 1'b1) : den_sel;
      dvd_sel = abs_num << sh_q[fidx];
   end

   always_comb begin
      sat = (div.div_quotient_in > MAXQ);
      mag = sat ? MAXQ[QWIDTH-1:0] : div.div_quotient_in[QWIDTH-1:0];
      res = neg_q ? (~mag + 1'b1) : mag;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         for (int j = 0; j < NJOBS; j++) begin
            num_q[j] <= '0;
            den_q[j] <= '0;
            sh_q[j]  <= '0;
         end
         en_q    <= '0;
         idx_q   <= '0;
         cur_q   <= '0;
         tmo_q   <= '0;
         neg_q   <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         quot_q  <= '0;
         err_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               if (start_in) begin
                  for (int j = 0; j < NJOBS; j++) begin
                     num_q[j] <= num_in[j*WIDTH +: WIDTH];
                     den_q[j] <= den_in[j*WIDTH +: WIDTH];
                     sh_q[j]  <= shift_in[j*SHW +: SHW];
                  end
                  en_q    <= en_in;
                  quot_q  <= '0;
                  err_q   <= '0;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!found) begin
                  state_q <= S_DONE;
               end else if (den_sel == '0) begin
                  quot_q[fidx*QWIDTH +: QWIDTH] <= '0;
                  err_q[fidx] <= 1'b1;
                  idx_q       <= IW'(fidx) + IW'(1);
               end else begin
                  cur_q   <= fidx;
                  dvd_q   <= dvd_sel;
                  dvs_q   <= abs_den;
                  neg_q   <= num_sel[WIDTH-1] ^ den_sel[WIDTH-1];
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!div.div_busy_in) begin
                  start_q <= 1'b1;
                  tmo_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               start_q <= 1'b0;
               if (div.div_valid_in) begin
                  if (div.div_error_in) begin
                     quot_q[cur_q*QWIDTH +: QWIDTH] <= '0;
                     err_q[cur_q] <= 1'b1;
                  end else begin
                     quot_q[cur_q*QWIDTH +: QWIDTH] <= res;
                     err_q[cur_q] <= sat;
                  end
                  idx_q   <= IW'(cur_q) + IW'(1);
                  state_q <= S_SCAN;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  quot_q[cur_q*QWIDTH +: QWIDTH] <= '0;
                  err_q[cur_q] <= 1'b1;
                  idx_q   <= IW'(cur_q) + IW'(1);
                  state_q <= S_SCAN;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_DONE: begin
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_out             = busy_q;
   assign quot_out             = quot_q;
   assign err_out              = err_q;
   assign valid_out            = valid_q;
   assign div.div_dividend_out = dvd_q;
   assign div.div_divisor_out  = dvs_q;
   assign div.div_start_out    = start_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural divider on the slave side, expected
// operands and batch results queued at stimulus time and checked on output.
module tb_div_scheduler;

   localparam int W   = 61;
   localparam int QW  = 32;
   localparam int NJ  = 4;
   localparam int SHW = 6;
   localparam int TMO = 16;
   localparam int LAT = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [NJ-1:0]    en_in;
   logic [NJ*W-1:0]  num_in;
   logic [NJ*W-1:0]  den_in;
   logic [NJ*SHW-1:0] shift_in;
   logic             busy;
   logic [NJ*QW-1:0] quot;
   logic [NJ-1:0]    err;
   logic             valid;

   logic             tb_busy;
   logic             tb_stale;
   logic             mdl_valid;
   logic             mdl_busy;
   logic             mdl_err;
   logic [W-1:0]     mdl_q;
   int               mdl_pend;

   div_scheduler_if #(.WIDTH(W)) dif ();

   div_scheduler #(
      .WIDTH(W), .QWIDTH(QW), .NJOBS(NJ), .SHW(SHW), .TIMEOUT(TMO)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .start_in (start),
      .en_in    (en_in),
      .num_in   (num_in),
      .den_in   (den_in),
      .shift_in (shift_in),
      .busy_out (busy),
      .quot_out (quot),
      .err_out  (err),
      .valid_out(valid),
      .div      (dif)
   );

   always #5 clk = ~clk;

   // Divisor 777 is never answered; divisor 555 answers with an error.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_pend  <= 0;
         mdl_valid <= 1'b0;
         mdl_busy  <= 1'b0;
         mdl_err   <= 1'b0;
         mdl_q     <= '0;
      end else begin
         mdl_valid <= 1'b0;
         mdl_err   <= 1'b0;
         if (mdl_pend != 0) begin
            mdl_pend <= mdl_pend - 1;
            if (mdl_pend == 1) begin
               mdl_valid <= 1'b1;
               mdl_busy  <= 1'b0;
               mdl_err   <= (dif.div_divisor_out == W'(555));
            end
         end else if (dif.div_start_out && dif.div_divisor_out != W'(777)) begin
            mdl_q    <= dif.div_dividend_out / dif.div_divisor_out;
            mdl_pend <= LAT;
            mdl_busy <= 1'b1;
         end
      end
   end

   assign dif.div_valid_in    = mdl_valid | tb_stale;
   assign dif.div_quotient_in = tb_stale ? W'(12345) : mdl_q;
   assign dif.div_busy_in     = mdl_busy | tb_busy;
   assign dif.div_error_in    = mdl_err;

   typedef struct packed {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
   } op_t;

   typedef struct packed {
      logic [NJ*QW-1:0] q;
      logic [NJ-1:0]    e;
   } res_t;

   op_t  op_q [$];
   res_t res_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [NJ-1:0] b_en;
   longint        b_num [NJ];
   longint        b_den [NJ];
   int            b_sh  [NJ];

   int n_strobe;
   int st_k [4];
   int valid_k;

   function automatic void model_job(input longint n, input longint d, input int s,
                                     output logic [QW-1:0] q, output logic e,
                                     output logic [W-1:0] dvd, output logic [W-1:0] dvs);
      logic [63:0] an, ad, m;
      an  = (n < 0) ? 64'(-n) : 64'(n);
      ad  = (d < 0) ? 64'(-d) : 64'(d);
      dvd = W'(an << s);
      dvs = W'(ad);
      q   = '0;
      e   = 1'b1;
      if (d != 0 && ad != 64'd777 && ad != 64'd555) begin
         m = 64'(dvd) / 64'(dvs);
         e = 1'b0;
         if (m > 64'h7fff_ffff) begin
            m = 64'h7fff_ffff;
            e = 1'b1;
         end
         q = ((n < 0) != (d < 0)) ? QW'(-m) : QW'(m);
      end
   endfunction

   task automatic set_job(input int j, input longint n, input longint d, input int s);
      b_num[j] = n;
      b_den[j] = d;
      b_sh[j]  = s;
   endtask

   task automatic drive_jobs();
      for (int j = 0; j < NJ; j++) begin
         num_in[j*W +: W]       = W'(b_num[j]);
         den_in[j*W +: W]       = W'(b_den[j]);
         shift_in[j*SHW +: SHW] = SHW'(b_sh[j]);
      end
   endtask

   task automatic run_batch(input int busy_cyc, input bit restart);
      res_t             r;
      op_t              o;
      logic [QW-1:0]    q;
      logic             e;
      logic [W-1:0]     dvd, dvs;
      r = '0;
      for (int j = 0; j < NJ; j++) begin
         if (b_en[j]) begin
            model_job(b_num[j], b_den[j], b_sh[j], q, e, dvd, dvs);
            r.q[j*QW +: QW] = q;
            r.e[j]          = e;
            if (b_den[j] != 0) op_q.push_back('{dvd: dvd, dvs: dvs});
         end
      end
      res_q.push_back(r);
      n_strobe = 0;
      valid_k  = -1;
      drive_jobs();
      @(negedge clk);
      start   = 1'b1;
      en_in   = b_en;
      tb_busy = (busy_cyc > 0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (start) start = 1'b0;
         if (k == busy_cyc + 1) tb_busy = 1'b0;
         if (dif.div_start_out) begin
            if (n_strobe < 4) st_k[n_strobe] = k;
            n_strobe++;
            n_checks++;
            if (op_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: strobe %0d at cycle %0d, none expected", n_strobe, k);
            end else begin
               o = op_q.pop_front();
               if ({dif.div_dividend_out, dif.div_divisor_out} !== {o.dvd, o.dvs}) begin
                  n_fail++;
                  $display("FAIL operands: got dvd=%0h dvs=%0h expected dvd=%0h dvs=%0h",
                           dif.div_dividend_out, dif.div_divisor_out, o.dvd, o.dvs);
               end
            end
            if (restart && n_strobe == 1) begin
               start  = 1'b1;
               en_in  = '1;
               num_in = ~num_in;
            end
         end
         if (valid) begin
            valid_k = k;
            break;
         end
      end
      tb_busy = 1'b0;
      n_checks++;
      if (valid_k < 0) begin
         n_fail++;
         $display("FAIL valid_timeout: no valid_out within 400 cycles, expected one");
         res_q.delete();
         op_q.delete();
      end else begin
         r = res_q.pop_front();
         n_checks++;
         if (quot !== r.q) begin
            n_fail++;
            $display("FAIL quot: got %h expected %h", quot, r.q);
         end
         n_checks++;
         if (err !== r.e) begin
            n_fail++;
            $display("FAIL err: got %b expected %b", err, r.e);
         end
         n_checks++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_valid: got %b expected 0", busy);
         end
         n_checks++;
         if (op_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes: %0d expected strobes not seen, expected 0", op_q.size());
            op_q.delete();
         end
         @(negedge clk);
         n_checks++;
         if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse: valid still %b one cycle later, expected 0", valid);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({busy, valid, dif.div_start_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy/valid/strobe=%b expected 000", {busy, valid, dif.div_start_out});
      end
      n_checks++;
      if (quot !== '0 || err !== '0) begin
         n_fail++;
         $display("FAIL reset_results: got quot=%h err=%b expected 0", quot, err);
      end
      n_checks++;
      if (dif.div_dividend_out !== '0 || dif.div_divisor_out !== '0) begin
         n_fail++;
         $display("FAIL reset_operands: got %h/%h expected 0", dif.div_dividend_out, dif.div_divisor_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      b_en = 4'b0011;
      set_job(0, -300, 100, 0);
      set_job(1, 5, 2, 8);
      set_job(2, 0, 0, 0);
      set_job(3, 0, 0, 0);
      run_batch(0, 1'b0);
      n_checks++;
      if (n_strobe != 2) begin
         n_fail++;
         $display("FAIL basic_strobes: got %0d expected 2", n_strobe);
      end
      n_checks++;
      if (st_k[0] != 2) begin
         n_fail++;
         $display("FAIL basic_issue_latency: got %0d expected 2", st_k[0]);
      end
      n_checks++;
      if (quot[0 +: QW] !== 32'hFFFF_FFFD || quot[QW +: QW] !== 32'd640) begin
         n_fail++;
         $display("FAIL basic_values: got q0=%0d q1=%0d expected -3 640",
                  $signed(quot[0 +: QW]), $signed(quot[QW +: QW]));
      end
   endtask

   task automatic test_mixed_skip();
      b_en = 4'b1101;
      set_job(0, 7, -2, 0);
      set_job(1, 99, 3, 0);
      set_job(2, 42, 0, 0);
      set_job(3, -9, -3, 0);
      run_batch(0, 1'b0);
      n_checks++;
      if (n_strobe != 2) begin
         n_fail++;
         $display("FAIL mixed_strobes: got %0d expected 2", n_strobe);
      end
   endtask

   task automatic test_saturation();
      b_en = 4'b1111;
      set_job(0, longint'(1) << 40, 1, 0);
      set_job(1, -(longint'(1) << 40), 1, 0);
      set_job(2, -(longint'(1) << 60), -(longint'(1) << 60), 0);
      set_job(3, 3, longint'(1) << 59, 60);
      run_batch(0, 1'b0);
      n_checks++;
      if (quot[0 +: QW] !== 32'd2147483647 || quot[QW +: QW] !== 32'h8000_0001 || err[1:0] !== 2'b11) begin
         n_fail++;
         $display("FAIL saturation: got q0=%0d q1=%0d err=%b expected 2147483647 -2147483647 11",
                  $signed(quot[0 +: QW]), $signed(quot[QW +: QW]), err[1:0]);
      end
   endtask

   task automatic test_timeout();
      b_en = 4'b0111;
      set_job(0, 10, 777, 0);
      set_job(1, 100, 7, 0);
      set_job(2, 1000, -555, 0);
      set_job(3, 0, 0, 0);
      run_batch(0, 1'b0);
      n_checks++;
      if (n_strobe != 3) begin
         n_fail++;
         $display("FAIL timeout_strobes: got %0d expected 3", n_strobe);
      end
      n_checks++;
      if (st_k[1] - st_k[0] != TMO + 2) begin
         n_fail++;
         $display("FAIL timeout_gap: got %0d cycles expected %0d", st_k[1] - st_k[0], TMO + 2);
      end
   endtask

   task automatic test_busy_ignore();
      b_en = 4'b0001;
      set_job(0, 1000, 10, 0);
      set_job(1, 0, 0, 0);
      set_job(2, 0, 0, 0);
      set_job(3, 0, 0, 0);
      run_batch(5, 1'b1);
      n_checks++;
      if (st_k[0] != 7) begin
         n_fail++;
         $display("FAIL busy_stall: strobe at cycle %0d expected 7", st_k[0]);
      end
      n_checks++;
      if (n_strobe != 1) begin
         n_fail++;
         $display("FAIL restart_ignored: got %0d strobes expected 1", n_strobe);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || dif.div_start_out !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_idle: got busy=%b strobe=%b expected 0 0", busy, dif.div_start_out);
      end
   endtask

   task automatic test_empty();
      b_en = 4'b0000;
      run_batch(0, 1'b0);
      n_checks++;
      if (valid_k != 2) begin
         n_fail++;
         $display("FAIL empty_latency: got %0d expected 2", valid_k);
      end
      n_checks++;
      if (n_strobe != 0) begin
         n_fail++;
         $display("FAIL empty_strobes: got %0d expected 0", n_strobe);
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      bit vbad;
      b_en = 4'b0001;
      set_job(0, 50, 777, 0);
      drive_jobs();
      @(negedge clk);
      start = 1'b1;
      en_in = b_en;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dif.div_start_out) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL areset_issue: no strobe within 20 cycles, expected one");
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || dif.div_dividend_out !== W'(50)) begin
         n_fail++;
         $display("FAIL areset_wait: got busy=%b dvd=%0d expected 1 50", busy, dif.div_dividend_out);
      end
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, valid, dif.div_start_out} !== 3'b000 || dif.div_dividend_out !== '0 || dif.div_divisor_out !== '0) begin
         n_fail++;
         $display("FAIL areset_immediate: got busy/valid/strobe=%b dvd=%h dvs=%h expected 0",
                  {busy, valid, dif.div_start_out}, dif.div_dividend_out, dif.div_divisor_out);
      end
      vbad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (valid !== 1'b0) vbad = 1'b1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      tb_stale = 1'b1;
      @(negedge clk);
      tb_stale = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (valid !== 1'b0) vbad = 1'b1;
      end
      n_checks++;
      if (vbad) begin
         n_fail++;
         $display("FAIL areset_no_valid: valid_out seen after abandoned batch, expected none");
      end
      n_checks++;
      if (quot !== '0 || err !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_valid: got quot=%h err=%b busy=%b expected 0 0 0", quot, err, busy);
      end
      test_basic();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      en_in    = '0;
      num_in   = '0;
      den_in   = '0;
      shift_in = '0;
      tb_busy  = 1'b0;
      tb_stale = 1'b0;
      for (int j = 0; j < NJ; j++) set_job(j, 0, 0, 0);
      test_reset();
      test_basic();
      test_mixed_skip();
      test_saturation();
      test_timeout();
      test_busy_ignore();
      test_empty();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Time-shares one unsigned shared divider (dividend/divisor in, quotient/valid/error/busy out) between up to NJOBS signed division jobs.
- Serves the linear-regression path (intercept/slope numerators over the denominator, forward and reverse fits), replacing one divider instance per term.
- Each job goes through sign extraction, abs, optional left shift (fixed-point scaling), issue, collection, saturation and sign restore.
- All results are presented together with a single valid pulse.

Parameters:
- WIDTH, 61, signed operand width and divider operand width.
- QWIDTH, 32, signed result width per job.
- NJOBS, 4, number of job slots.
- SHW, 6, width of the per-job shift field.
- TIMEOUT, 255, max cycles in WAIT before the job is forced to error.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  capture all jobs; honoured only in IDLE.
- en_in  in  NJOBS  per-job enable mask, captured with start_in.
- num_in  in  NJOBS*WIDTH  signed numerators; job j occupies [j*WIDTH +: WIDTH].
- den_in  in  NJOBS*WIDTH  signed denominators, same packing.
- shift_in  in  NJOBS*SHW  left shift applied to abs(numerator).
- busy_out  in/out  out 1  high from the cycle after an accepted start until DONE.
- quot_out  out  NJOBS*QWIDTH  signed quotients; held until the next accepted start.
- err_out  out  NJOBS  per-job error flags; held like quot_out.
- valid_out  out  1  one-cycle pulse when all jobs are resolved.
- div_dividend_out  out  WIDTH  unsigned dividend to the shared divider.
- div_divisor_out  out  WIDTH  unsigned divisor to the shared divider.
- div_start_out  out  1  one-cycle issue strobe (divider data_valid_in).
- div_quotient_in  in  WIDTH  divider quotient.
- div_valid_in  in  1  divider result strobe.
- div_error_in  in  1  divider error, sampled with div_valid_in.
- div_busy_in  in  1  divider busy.

Behaviour:
- Reset (async, rst_n_in=0):
  - State goes to IDLE. quot_out=0, err_out=0, valid_out=0, busy_out=0, div_start_out=0, div operand outputs=0, job index=0, timeout counter=0.
  - Reset mid-operation abandons the batch with no valid_out. A late div_valid_in after reset is ignored in IDLE.
- Job slots:
  - Registered copies of num, den, shift and en. They are captured only in IDLE on start_in.
  - On the same edge: quot_out and err_out clear to 0, busy_out rises.
  - start_in outside IDLE is ignored with no side effects.
- State SCAN:
  - Find the lowest index j ≥ current index with en[j]=1. If none, go to DONE.
  - If den[j]==0: quot[j]=0, err[j]=1, no issue; advance index, stay in SCAN (1 cycle per skipped job).
  - Otherwise go to ISSUE.
- State ISSUE:
  - Operand outputs are registered from job j:
    - dividend = abs(num[j]) << shift[j], truncated to WIDTH bits unsigned.
    - divisor = abs(den[j]).
    - neg[j] = num[j][WIDTH-1] ^ den[j][WIDTH-1].
  - abs(most-negative) equals 2^(WIDTH-1) unsigned and is not an error.
  - Wait while div_busy_in=1. When it is low, assert div_start_out for exactly 1 cycle, clear the timeout counter, go to WAIT.
  - Operand outputs stay stable from the strobe until div_valid_in.
- State WAIT:
  - On div_valid_in, with magnitude m = div_quotient_in:
    - If div_error_in=1: quot=0, err=1.
    - Else if m > 2^(QWIDTH-1)-1: saturate m to 2^(QWIDTH-1)-1 and set err=1.
    - Else err=0.
    - quot[j] = neg ? -m : m.
    - Advance index, go to SCAN.
  - If the counter reaches TIMEOUT with no div_valid_in: quot=0, err=1, advance, go to SCAN.
  - div_valid_in outside WAIT is ignored.
- State DONE:
  - valid_out=1 for one cycle, busy_out=0 on the same edge, then IDLE.
- Latency:
  - A batch with no enabled jobs gives valid_out 2 cycles after the start edge (SCAN, DONE).
  - Each issued job costs 1 (SCAN) + 1 + busy stall (ISSUE) + divider latency cycles (WAIT).
- Job order is strictly ascending index; exactly one divider operation is outstanding at a time.

Test Plan:
- Basic batch, en=4'b0011:
  - Stimulus: job0 num=-300 den=100 sh=0; job1 num=5 den=2 sh=8.
  - Response: quot0=-3, quot1=640, err=0, valid_out single pulse, exactly 2 div_start_out strobes.
- Mixed skip, en=4'b1101:
  - Stimulus: job0 num=7 den=-2; job2 den=0; job3 num=-9 den=-3.
  - Response: quot={3,0,0,-3} for jobs 3..0 (quot3=3, quot2=0, quot1=0, quot0=-3), err=4'b0100, 2 strobes, job1 untouched at 0.
- Saturation, QWIDTH=32:
  - Stimulus: num=2^40 den=1.
  - Response: quot=2147483647, err=1.
  - Stimulus: num=-2^40 den=1.
  - Response: quot=-2147483647, err=1.
- Timeout, TIMEOUT=16:
  - Stimulus: divider never returns valid.
  - Response: after 16 WAIT cycles quot=0 and err set, next job issues, valid_out still fires.
- Busy/ignore:
  - Stimulus: start_in pulsed again during WAIT.
  - Response: slots unchanged, no extra strobe. Stimulus: div_busy_in held 5 cycles in ISSUE; response: strobe delayed 5 cycles.
  - Stimulus: en=0.
  - Response: valid_out 2 cycles after start, no strobe.
- Async reset:
  - Stimulus: rst_n_in low mid-WAIT (asynchronous to clk_in).
  - Response: outputs 0 immediately, no valid_out. Stimulus: stale div_valid_in after release; response: no change; a fresh batch then completes correctly.
